// File: rtl/sr_cmd_pkg.sv
// ---------------------------------------------------------------------------
// sr_cmd_pkg
// Shared definitions for the pushbutton-to-SR command generator.
//   db_state_t       : per-channel debounce state (IDLE, PRESS, HELD, REL)
//   SYNC_STAGES_DEF  : default synchronizer depth
//   DB_CYCLES_DEF    : default number of stable samples to qualify an edge
// ---------------------------------------------------------------------------
package sr_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HELD  = 2'd2,
        REL   = 2'd3
    } db_state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DB_CYCLES_DEF   = 16;

endpackage

// File: rtl/sr_cmd_gen_if.sv
// ---------------------------------------------------------------------------
// sr_cmd_gen_if
// Bundles the raw button inputs and the SR command outputs.
//   set_btn, clr_btn : raw asynchronous buttons, active-high
//   s, r             : one-cycle set / reset pulses to the SR stage
//   conflict         : one-cycle pulse when both channels qualify together
// Modports:
//   master : the command generator (takes buttons, drives commands)
//   slave  : the button source / SR stage side
// ---------------------------------------------------------------------------
interface sr_cmd_gen_if;

    logic set_btn;
    logic clr_btn;
    logic s;
    logic r;
    logic conflict;

    modport master (
        input  set_btn,
        input  clr_btn,
        output s,
        output r,
        output conflict
    );

    modport slave (
        output set_btn,
        output clr_btn,
        input  s,
        input  r,
        input  conflict
    );

endinterface

// File: rtl/sr_db_chan.sv
// ---------------------------------------------------------------------------
// sr_db_chan
// One button channel: SYNC_STAGES-flop synchronizer, debounce FSM and
// counter. Raises 'fire' for exactly one cycle per qualified press; the
// press must be qualified as released before the channel can fire again.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   btn        : raw asynchronous button
//   fire       : registered one-cycle strobe on a qualified press
// Build option SR_CMD_GEN_DEBOUNCE_EN:
//   defined   : DB_CYCLES consecutive samples qualify a press / release
//   undefined : no counter, a single synced sample qualifies (DB_CYCLES
//               is ignored)
// ---------------------------------------------------------------------------
module sr_db_chan
    import sr_cmd_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic fire
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    db_state_t              state_q, state_d;
    logic                   fire_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef SR_CMD_GEN_DEBOUNCE_EN

    localparam int              CNT_W   = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // With a one-sample window the first sample already qualifies, so the
    // counting states are skipped entirely.
    localparam bit               SINGLE  = (DB_CYCLES == 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fire    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fire    <= fire_d;
        end
    end

    // The counter holds the number of consecutive samples already seen at
    // the new level; qualification happens on the sample that would make
    // it reach DB_CYCLES, and it is pinned there rather than wrapping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (synced) begin
                    if (SINGLE) begin
                        state_d = HELD;
                        cnt_d   = CNT_MAX;
                        fire_d  = 1'b1;
                    end else begin
                        state_d = PRESS;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            PRESS: begin
                if (!synced) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_MAX - CNT_ONE) begin
                    state_d = HELD;
                    cnt_d   = CNT_MAX;
                    fire_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!synced) begin
                    if (SINGLE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = REL;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            REL: begin
                if (synced) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_MAX - CNT_ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`else

    // DB_CYCLES has no effect in this build.
    logic db_cycles_unused;
    assign db_cycles_unused = (DB_CYCLES > 0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fire    <= 1'b0;
        end else begin
            state_q <= state_d;
            fire    <= fire_d;
        end
    end

    // One synced high sample qualifies a press, one low sample a release.
    always_comb begin
        state_d = state_q;
        fire_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (synced) begin
                    state_d = HELD;
                    fire_d  = 1'b1;
                end
            end
            HELD: begin
                if (!synced) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`endif

endmodule

// File: rtl/sr_cmd_gen.sv
// ---------------------------------------------------------------------------
// sr_cmd_gen
// Turns the raw set / clear pushbuttons into synchronized, debounced,
// single-cycle s / r command pulses. If both channels qualify in the same
// cycle neither command is issued and 'conflict' pulses instead, so s and
// r are never high together.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : sr_cmd_gen_if.master (set_btn, clr_btn in; s, r,
//                conflict out)
// Build option SR_CMD_GEN_DEBOUNCE_EN (see sr_db_chan): enables the
// DB_CYCLES debounce window; without it one synced sample qualifies.
// ---------------------------------------------------------------------------
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    sr_cmd_gen_if.master bus
);

    logic set_fire;
    logic clr_fire;

    sr_db_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_set_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.set_btn),
        .fire  (set_fire)
    );

    sr_db_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_clr_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.clr_btn),
        .fire  (clr_fire)
    );

    // Registered command stage: a simultaneous qualification is reported
    // as a conflict and suppresses both commands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.s        <= 1'b0;
            bus.r        <= 1'b0;
            bus.conflict <= 1'b0;
        end else begin
            bus.s        <= set_fire & ~clr_fire;
            bus.r        <= clr_fire & ~set_fire;
            bus.conflict <= set_fire & clr_fire;
        end
    end

endmodule
